// File: rtl/uart_cfg.sv
// Runtime-configurable UART: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits,
// TX/RX FIFOs with toggle handshakes, per-byte RX error status and internal loopback.
module uart_cfg #(
   parameter int FIFO_DEPTH = 64,
   parameter bit TX_ENABLE  = 1'b1,
   parameter bit RX_ENABLE  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] baud_div,
   input  logic [1:0]  cfg_data_bits,
   input  logic [1:0]  cfg_parity,
   input  logic        cfg_stop2,
   input  logic        cfg_loopback,
   input  logic        uart_tx_start,
   input  logic [7:0]  uart_tx_data_in,
   output logic        uart_tx_pin,
   output logic        uart_tx_fifo_full,
   output logic        uart_tx_fifo_empty,
   output logic        uart_tx_overflow,
   input  logic        uart_rx_pin,
   input  logic        uart_rx_read,
   output logic        uart_rx_ready,
   output logic [7:0]  uart_rx_byte,
   output logic        uart_rx_parity_err,
   output logic        uart_rx_frame_err,
   output logic        uart_rx_overrun,
   input  logic        err_clear
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [15:0] div_eff;
   logic [3:0]  nbits_cfg;

   assign div_eff   = (baud_div < 16'd4) ? 16'd4 : baud_div;
   assign nbits_cfg = 4'd5 + {2'b00, cfg_data_bits};

   logic        tx_start_q, tx_event, tx_push, tx_pop, tx_full, tx_fifo_empty;
   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr, tx_rd;
   state_t      tx_state, tx_state_n;
   logic [15:0] tx_tmr, tx_div;
   logic [2:0]  tx_bit;
   logic [3:0]  tx_nbits;
   logic        tx_par_en, tx_odd, tx_stop2, tx_stop_cnt, tx_par, tx_line, tx_line_n, tx_ovf;
   logic [7:0]  tx_shift;

   assign tx_event      = TX_ENABLE && (uart_tx_start != tx_start_q);
   assign tx_full       = (tx_wr - tx_rd) == DEPTH;
   assign tx_fifo_empty = tx_wr == tx_rd;
   assign tx_push       = tx_event && (!tx_full || tx_pop);
   assign tx_par        = (^(tx_shift & (8'hFF >> (4'd8 - tx_nbits)))) ^ tx_odd;

   // The line value is registered, so the start bit appears one edge after the FSM leaves IDLE.
   always_comb begin
      tx_state_n = tx_state;
      tx_pop     = 1'b0;
      tx_line_n  = 1'b1;
      case (tx_state)
         S_IDLE:
            if (!tx_fifo_empty) begin
               tx_state_n = S_START;
               tx_pop     = 1'b1;
            end
         S_START: begin
            tx_line_n = 1'b0;
            if (tx_tmr == 16'd0) tx_state_n = S_DATA;
         end
         S_DATA: begin
            tx_line_n = tx_shift[tx_bit];
            if (tx_tmr == 16'd0 && {1'b0, tx_bit} == tx_nbits - 4'd1)
               tx_state_n = tx_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx_line_n = tx_par;
            if (tx_tmr == 16'd0) tx_state_n = S_STOP;
         end
         S_STOP:
            if (tx_tmr == 16'd0 && (!tx_stop2 || tx_stop_cnt)) begin
               if (!tx_fifo_empty) begin
                  tx_state_n = S_START;
                  tx_pop     = 1'b1;
               end else begin
                  tx_state_n = S_IDLE;
               end
            end
         default: tx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr[AW-1:0]] <= uart_tx_data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_start_q  <= uart_tx_start;
         tx_wr       <= '0;
         tx_rd       <= '0;
         tx_state    <= S_IDLE;
         tx_tmr      <= 16'd0;
         tx_div      <= 16'd4;
         tx_bit      <= 3'd0;
         tx_nbits    <= 4'd8;
         tx_par_en   <= 1'b0;
         tx_odd      <= 1'b0;
         tx_stop2    <= 1'b0;
         tx_stop_cnt <= 1'b0;
         tx_shift    <= 8'd0;
         tx_line     <= 1'b1;
         tx_ovf      <= 1'b0;
      end else begin
         tx_start_q <= uart_tx_start;
         tx_state   <= tx_state_n;
         tx_line    <= tx_line_n;
         if (tx_push) tx_wr <= tx_wr + PTR_ONE;
         if (tx_pop) begin
            tx_rd     <= tx_rd + PTR_ONE;
            tx_shift  <= tx_mem[tx_rd[AW-1:0]];
            tx_div    <= div_eff;
            tx_nbits  <= nbits_cfg;
            tx_par_en <= ^cfg_parity;
            tx_odd    <= (cfg_parity == 2'b10);
            tx_stop2  <= cfg_stop2;
         end
         if (tx_pop || tx_tmr == 16'd0) tx_tmr <= (tx_pop ? div_eff : tx_div) - 16'd1;
         else                           tx_tmr <= tx_tmr - 16'd1;
         if (tx_pop)                                   tx_bit <= 3'd0;
         else if (tx_state == S_DATA && tx_tmr == 16'd0) tx_bit <= tx_bit + 3'd1;
         if (tx_pop)                                   tx_stop_cnt <= 1'b0;
         else if (tx_state == S_STOP && tx_tmr == 16'd0) tx_stop_cnt <= 1'b1;
         if (err_clear)            tx_ovf <= 1'b0;
         if (tx_event && !tx_push) tx_ovf <= 1'b1;
      end
   end

   logic        rx_read_q, rx_event, rx_s1, rx_s2, rx_src, rx_pop, rx_store, rx_wr_en;
   logic        rx_full, rx_fifo_empty;
   logic [9:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] rx_wr, rx_rd;
   state_t      rx_state, rx_state_n;
   logic [15:0] rx_tmr, rx_div;
   logic [2:0]  rx_bit;
   logic [3:0]  rx_nbits;
   logic        rx_par_en, rx_odd, rx_perr, rx_ovf;
   logic [7:0]  rx_data;

   assign rx_src        = cfg_loopback ? tx_line : uart_rx_pin;
   assign rx_event      = RX_ENABLE && (uart_rx_read != rx_read_q);
   assign rx_full       = (rx_wr - rx_rd) == DEPTH;
   assign rx_fifo_empty = rx_wr == rx_rd;
   assign rx_pop        = rx_event && !rx_fifo_empty;
   assign rx_wr_en      = RX_ENABLE && rx_store && (!rx_full || rx_pop);

   // START re-checks the line at mid-bit so a short glitch is rejected without storing anything.
   always_comb begin
      rx_state_n = rx_state;
      rx_store   = 1'b0;
      case (rx_state)
         S_IDLE:   if (!rx_s2) rx_state_n = S_START;
         S_START:  if (rx_tmr == 16'd0) rx_state_n = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:
            if (rx_tmr == 16'd0 && {1'b0, rx_bit} == rx_nbits - 4'd1)
               rx_state_n = rx_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (rx_tmr == 16'd0) rx_state_n = S_STOP;
         S_STOP:
            if (rx_tmr == 16'd0) begin
               rx_state_n = S_IDLE;
               rx_store   = 1'b1;
            end
         default:  rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= {~rx_s2, rx_perr, rx_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_read_q          <= uart_rx_read;
         rx_s1              <= 1'b1;
         rx_s2              <= 1'b1;
         rx_wr              <= '0;
         rx_rd              <= '0;
         rx_state           <= S_IDLE;
         rx_tmr             <= 16'd0;
         rx_div             <= 16'd4;
         rx_bit             <= 3'd0;
         rx_nbits           <= 4'd8;
         rx_par_en          <= 1'b0;
         rx_odd             <= 1'b0;
         rx_perr            <= 1'b0;
         rx_data            <= 8'd0;
         rx_ovf             <= 1'b0;
         uart_rx_byte       <= 8'd0;
         uart_rx_parity_err <= 1'b0;
         uart_rx_frame_err  <= 1'b0;
      end else begin
         rx_read_q <= uart_rx_read;
         rx_s1     <= rx_src;
         rx_s2     <= rx_s1;
         rx_state  <= rx_state_n;
         if (rx_state == S_IDLE) begin
            rx_tmr    <= (div_eff >> 1) - 16'd1;
            rx_bit    <= 3'd0;
            rx_data   <= 8'd0;
            rx_perr   <= 1'b0;
            rx_div    <= div_eff;
            rx_nbits  <= nbits_cfg;
            rx_par_en <= ^cfg_parity;
            rx_odd    <= (cfg_parity == 2'b10);
         end else if (rx_tmr == 16'd0) begin
            rx_tmr <= rx_div - 16'd1;
         end else begin
            rx_tmr <= rx_tmr - 16'd1;
         end
         if (rx_state == S_DATA && rx_tmr == 16'd0) begin
            rx_data[rx_bit] <= rx_s2;
            rx_bit          <= rx_bit + 3'd1;
         end
         if (rx_state == S_PARITY && rx_tmr == 16'd0) rx_perr <= rx_s2 ^ (^rx_data) ^ rx_odd;
         if (rx_wr_en) rx_wr <= rx_wr + PTR_ONE;
         if (rx_pop) begin
            rx_rd              <= rx_rd + PTR_ONE;
            uart_rx_byte       <= rx_mem[rx_rd[AW-1:0]][7:0];
            uart_rx_parity_err <= rx_mem[rx_rd[AW-1:0]][8];
            uart_rx_frame_err  <= rx_mem[rx_rd[AW-1:0]][9];
         end else if (rx_event) begin
            uart_rx_byte       <= 8'd0;
            uart_rx_parity_err <= 1'b0;
            uart_rx_frame_err  <= 1'b0;
         end
         if (err_clear)                        rx_ovf <= 1'b0;
         if (RX_ENABLE && rx_store && !rx_wr_en) rx_ovf <= 1'b1;
      end
   end

   assign uart_tx_pin        = (TX_ENABLE && !cfg_loopback) ? tx_line : 1'b1;
   assign uart_tx_fifo_full  = TX_ENABLE && tx_full;
   assign uart_tx_fifo_empty = !TX_ENABLE || (tx_fifo_empty && tx_state == S_IDLE);
   assign uart_tx_overflow   = tx_ovf;
   assign uart_rx_ready      = RX_ENABLE && !rx_fifo_empty;
   assign uart_rx_overrun    = rx_ovf;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed + randomized bench for uart_cfg; expected frames and bytes come from a
// bit-list model of the serial format and a queue of accepted bytes.
module tb_uart_cfg;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] baud_div = 16'd8;
   logic [1:0]  cfg_data_bits = 2'd3;
   logic [1:0]  cfg_parity = 2'd0;
   logic        cfg_stop2 = 1'b0;
   logic        cfg_loopback = 1'b0;
   logic        uart_tx_start = 1'b0;
   logic [7:0]  uart_tx_data_in = 8'd0;
   logic        uart_tx_pin, uart_tx_fifo_full, uart_tx_fifo_empty, uart_tx_overflow;
   logic        uart_rx_pin = 1'b1;
   logic        uart_rx_read = 1'b0;
   logic        uart_rx_ready, uart_rx_parity_err, uart_rx_frame_err, uart_rx_overrun;
   logic [7:0]  uart_rx_byte;
   logic        err_clear = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   bit exp_bits[$];
   int exp_q[$];

   uart_cfg #(.FIFO_DEPTH(DEPTH), .TX_ENABLE(1'b1), .RX_ENABLE(1'b1)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_loopback(cfg_loopback),
      .uart_tx_start(uart_tx_start), .uart_tx_data_in(uart_tx_data_in),
      .uart_tx_pin(uart_tx_pin), .uart_tx_fifo_full(uart_tx_fifo_full),
      .uart_tx_fifo_empty(uart_tx_fifo_empty), .uart_tx_overflow(uart_tx_overflow),
      .uart_rx_pin(uart_rx_pin), .uart_rx_read(uart_rx_read), .uart_rx_ready(uart_rx_ready),
      .uart_rx_byte(uart_rx_byte), .uart_rx_parity_err(uart_rx_parity_err),
      .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_overrun(uart_rx_overrun),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_cfg(input int div, input int db, input int par, input bit stop2, input bit lb);
      baud_div = 16'(div);
      cfg_data_bits = 2'(db);
      cfg_parity = 2'(par);
      cfg_stop2 = stop2;
      cfg_loopback = lb;
   endtask

   task automatic push_byte(input int b);
      uart_tx_data_in = 8'(b);
      uart_tx_start = ~uart_tx_start;
      @(negedge clk);
   endtask

   task automatic pop_byte();
      uart_rx_read = ~uart_rx_read;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
   endtask

   task automatic wait_tx_idle(input int limit, input string tag);
      int n = 0;
      while (!uart_tx_fifo_empty && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_tx_idle"}, uart_tx_fifo_empty, 1);
   endtask

   task automatic wait_rx_ready(input int limit, input string tag);
      int n = 0;
      while (!uart_rx_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_rx_ready"}, uart_rx_ready, 1);
   endtask

   function automatic int eff_div(input int div);
      return (div < 4) ? 4 : div;
   endfunction

   function automatic int parity_of(input int d, input int nbits, input int par);
      int ones = 0;
      for (int i = 0; i < nbits; i++) ones += (d >> i) & 1;
      return (par == 2) ? 1 - (ones % 2) : ones % 2;
   endfunction

   // Serial image of one frame: start, data LSB first, optional parity, stop bit(s).
   function automatic void append_frame(input int d, input int db, input int par, input bit stop2);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < db + 5; i++) exp_bits.push_back(bit'((d >> i) & 1));
      if (par == 1 || par == 2) exp_bits.push_back(bit'(parity_of(d, db + 5, par)));
      exp_bits.push_back(1'b1);
      if (stop2) exp_bits.push_back(1'b1);
   endfunction

   task automatic check_wave(input string tag, input int div, input int db, input int par,
                             input bit stop2, input int b0, input int b1);
      int e = eff_div(div);
      apply_cfg(div, db, par, stop2, 1'b0);
      exp_bits.delete();
      append_frame(b0, db, par, stop2);
      append_frame(b1, db, par, stop2);
      push_byte(b0);
      check_output({tag, "_empty_after_push"}, uart_tx_fifo_empty, 0);
      push_byte(b1);
      check_output({tag, "_pin_before_start"}, uart_tx_pin, 1);
      @(negedge clk);
      check_output({tag, "_start_edge"}, uart_tx_pin, 0);
      cyc(e / 2);
      for (int k = 0; k < exp_bits.size(); k++) begin
         check_output($sformatf("%s_bit%0d", tag, k), uart_tx_pin, exp_bits[k]);
         cyc(e);
      end
      wait_tx_idle(4 * e, tag);
   endtask

   task automatic loop_rx(input string tag, input int div, input int db, input int par,
                          input bit stop2, input int d);
      int e = eff_div(div);
      apply_cfg(div, db, par, stop2, 1'b1);
      push_byte(d);
      cyc(3);
      check_output({tag, "_pin_held_loopback"}, uart_tx_pin, 1);
      wait_rx_ready(16 * e, tag);
      pop_byte();
      check_output({tag, "_byte"}, uart_rx_byte, d % (1 << (db + 5)));
      check_output({tag, "_parity_err"}, uart_rx_parity_err, 0);
      check_output({tag, "_frame_err"}, uart_rx_frame_err, 0);
      wait_tx_idle(16 * e, tag);
   endtask

   initial begin
      int v;
      int par_ok;
      // Reset and idle state
      cyc(3);
      rst = 1'b0;
      @(negedge clk);
      check_output("rst_tx_pin", uart_tx_pin, 1);
      check_output("rst_tx_empty", uart_tx_fifo_empty, 1);
      check_output("rst_tx_full", uart_tx_fifo_full, 0);
      check_output("rst_tx_overflow", uart_tx_overflow, 0);
      check_output("rst_rx_ready", uart_rx_ready, 0);
      check_output("rst_rx_byte", uart_rx_byte, 0);
      check_output("rst_rx_perr", uart_rx_parity_err, 0);
      check_output("rst_rx_ferr", uart_rx_frame_err, 0);
      check_output("rst_rx_overrun", uart_rx_overrun, 0);
      pop_byte();
      check_output("empty_read_byte", uart_rx_byte, 0);
      check_output("empty_read_ready", uart_rx_ready, 0);

      // Reset in the middle of a frame with 10 more bytes queued; toggle input ends at 1
      apply_cfg(8, 3, 0, 0, 0);
      for (int i = 0; i < 11; i++) push_byte($urandom_range(0, 255));
      cyc(30);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("midrst_pin", uart_tx_pin, 1);
      check_output("midrst_empty", uart_tx_fifo_empty, 1);
      check_output("midrst_full", uart_tx_fifo_full, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(30);
      check_output("postrst_start_level", uart_tx_start, 1);
      check_output("postrst_empty", uart_tx_fifo_empty, 1);
      check_output("postrst_pin", uart_tx_pin, 1);
      check_output("postrst_rx_ready", uart_rx_ready, 0);

      // Serial waveforms: 7E2 and 5O1 (the latter with baud_div 2, clamped to 4)
      check_wave("w7e2", 8, 2, 1, 1'b1, 8'h55, 8'h7F);
      check_wave("w5o1", 2, 0, 2, 1'b0, 8'h1F, 8'h55);
      check_wave("w8n2r", $urandom_range(4, 10), 3, 3, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255));

      // Loopback reception, fixed formats then random ones
      loop_rx("l7e2_55", 8, 2, 1, 1'b1, 8'h55);
      loop_rx("l7e2_7f", 8, 2, 1, 1'b1, 8'h7F);
      loop_rx("l5o1_1f", 8, 0, 2, 1'b0, 8'h1F);
      loop_rx("l5o1_55", 8, 0, 2, 1'b0, 8'h55);
      for (int i = 0; i < 6; i++)
         loop_rx($sformatf("lrand%0d", i), $urandom_range(1, 12), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255));

      // TX overflow: the first byte moves straight into the shifter, so DEPTH+1 are accepted
      apply_cfg(8, 3, 0, 0, 1);
      exp_q.delete();
      for (int i = 1; i <= 72; i++) begin
         push_byte(i);
         if (i <= DEPTH + 1) exp_q.push_back(i);
         if (i == DEPTH)     check_output("ovf_full_before", uart_tx_fifo_full, 0);
         if (i == DEPTH + 1) check_output("ovf_full_at", uart_tx_fifo_full, 1);
         if (i == DEPTH + 1) check_output("ovf_flag_before", uart_tx_overflow, 0);
         if (i == DEPTH + 2) check_output("ovf_flag_at", uart_tx_overflow, 1);
      end
      check_output("ovf_full_end", uart_tx_fifo_full, 1);
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         wait_rx_ready(200, $sformatf("ovf_rd%0d", v));
         pop_byte();
         check_output($sformatf("ovf_byte%0d", v), uart_rx_byte, v);
         check_output($sformatf("ovf_perr%0d", v), uart_rx_parity_err, 0);
         check_output($sformatf("ovf_ferr%0d", v), uart_rx_frame_err, 0);
      end
      cyc(200);
      check_output("ovf_no_extra", uart_rx_ready, 0);
      check_output("ovf_tx_drained", uart_tx_fifo_empty, 1);
      pulse_clear();
      check_output("ovf_cleared", uart_tx_overflow, 0);

      // External 8E1 frame for 0xA5 with inverted parity and a low stop bit
      apply_cfg(16, 3, 1, 0, 0);
      exp_bits.delete();
      par_ok = parity_of(8'hA5, 8, 1);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(bit'((8'hA5 >> i) & 1));
      exp_bits.push_back(bit'(1 - par_ok));
      exp_bits.push_back(1'b0);
      foreach (exp_bits[k]) begin
         uart_rx_pin = exp_bits[k];
         cyc(16);
      end
      uart_rx_pin = 1'b1;
      cyc(48);
      check_output("ext_ready", uart_rx_ready, 1);
      pop_byte();
      check_output("ext_byte", uart_rx_byte, 8'hA5);
      check_output("ext_perr", uart_rx_parity_err, 1);
      check_output("ext_ferr", uart_rx_frame_err, 1);
      check_output("ext_single_entry", uart_rx_ready, 0);

      // Glitch shorter than half a bit
      uart_rx_pin = 1'b0;
      cyc(16 / 4);
      uart_rx_pin = 1'b1;
      cyc(48);
      check_output("glitch_no_entry", uart_rx_ready, 0);

      // RX overrun: DEPTH+1 frames without reading
      apply_cfg(8, 3, 0, 0, 1);
      exp_q.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         v = $urandom_range(0, 255);
         exp_q.push_back(v);
         push_byte(v);
      end
      check_output("orun_tx_no_overflow", uart_tx_overflow, 0);
      wait_tx_idle((DEPTH + 1) * 80 + 300, "orun");
      cyc(20);
      check_output("orun_flag", uart_rx_overrun, 1);
      check_output("orun_ready", uart_rx_ready, 1);
      pulse_clear();
      check_output("orun_cleared", uart_rx_overrun, 0);
      pop_byte();
      check_output("orun_first_byte", uart_rx_byte, exp_q[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
